instruction_fetch: RTL and testbench

Front-end fetch stage. It owns the program counter, issues word reads to instruction memory over a request/grant bus with in-order responses, and buffers returned words in a small prefetch FIFO. Each cycle it drives the 64-bit `{pc, instruction}` register consumed by the decode/execute stage. It accepts that stage's `update_pc`/`new_pc` redirect, flushes in-flight and buffered work, and restarts fetch at the target.

---
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// Fetch stage: owns the pc, reads imem over req/gnt with in-order responses, buffers words in a prefetch FIFO.
// Optional IFETCH_BYPASS_EN: a response arriving with an empty FIFO goes straight to instruction_reg.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        update_pc,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] instruction_reg
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [63:0] BUBBLE = {32'd0, NOP};
  localparam logic [OW-1:0] DEPTH_OW = OW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  fetch_entry_t  fifo_mem [FIFO_DEPTH];

  logic [OW-1:0] occupancy_c;
  logic          grant_c;
  logic          accept_c;
  logic          fifo_empty_c;
  logic          bypass_c;
  logic          push_c;
  logic          pop_c;
  logic [31:0]   target_c;
  fetch_entry_t  resp_entry_c;

  // Request gating, response classification and FIFO movement for this cycle
  always_comb begin
    occupancy_c  = OW'(outstanding) + OW'(count);
    imem_req     = !update_pc && (occupancy_c < DEPTH_OW);
    imem_addr    = fetch_pc;
    grant_c      = imem_req && imem_gnt;
    accept_c     = imem_rvalid && (discard == '0);
    fifo_empty_c = (count == '0);
    target_c     = new_pc & 32'hFFFF_FFFC;
    resp_entry_c = '{pc: resp_pc, instr: imem_rdata};
`ifdef IFETCH_BYPASS_EN
    bypass_c     = fifo_empty_c && accept_c;
`else
    bypass_c     = 1'b0;
`endif
    push_c       = accept_c && !bypass_c && !update_pc;
    pop_c        = !fifo_empty_c && !update_pc;
  end

  // FIFO payload storage; occupancy is bounded so a push never lands on an unread slot
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= resp_entry_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetch_pc        <= RESET_PC;
      resp_pc         <= RESET_PC;
      outstanding     <= '0;
      discard         <= '0;
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      instruction_reg <= BUBBLE;
    end else if (update_pc) begin
      // Everything still in flight becomes stale, including a response landing this cycle
      fetch_pc        <= target_c;
      resp_pc         <= target_c;
      outstanding     <= outstanding - CW'(imem_rvalid);
      discard         <= outstanding - CW'(imem_rvalid);
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      instruction_reg <= BUBBLE;
    end else begin
      if (grant_c) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(grant_c) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (accept_c) begin
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop_c) begin
        instruction_reg <= fifo_mem[rd_ptr];
        rd_ptr          <= rd_ptr + PW'(1);
      end else if (bypass_c) begin
        instruction_reg <= resp_entry_c;
      end else begin
        instruction_reg <= BUBBLE;
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push_c) - CW'(pop_c);
    end
  end

  // Protocol invariants of the fetch bus
  a_addr_hold : assert property (@(posedge i_clk) disable iff (!i_rstn)
    (imem_req && !imem_gnt) |=> $stable(imem_addr));
  a_capacity : assert property (@(posedge i_clk) disable iff (!i_rstn)
    occupancy_c <= DEPTH_OW);
  a_no_spurious_rvalid : assert property (@(posedge i_clk) disable iff (!i_rstn)
    imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Bench for instruction_fetch: in-order random-latency memory, per-cycle reference model, directed scenarios.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;
`ifdef IFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        update_pc = 1'b0;
  logic [31:0] new_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [63:0] instruction_reg;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .update_pc(update_pc), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instruction_reg(instruction_reg)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit hold_rv = 1'b0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    last_due;

  logic [31:0] m_fetch, m_resp;
  int          m_out, m_disc;
  logic [63:0] m_q[$];
  logic [63:0] m_ireg;

  logic        s_req;
  logic [31:0] s_addr;
  logic [63:0] s_ireg;
  logic [31:0] last_pc;
  bit          last_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  function automatic bit m_req();
    return !update_pc && ((m_out + m_q.size()) < DEPTH);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch = RESET_PC; m_resp = RESET_PC;
    m_out = 0; m_disc = 0;
    m_q.delete();
    m_ireg = BUBBLE;
    pend.delete();
    last_due = -1;
    last_valid = 0;
  endtask

  // Advance the reference by one clock edge using the inputs currently applied
  task automatic model_step(input bit grant);
    logic [63:0] w;
    bit acc;
    acc = 0;
    w = {m_resp, imem_rdata};
    if (update_pc) begin
      m_fetch = {new_pc[31:2], 2'b00};
      m_resp = m_fetch;
      m_q.delete();
      m_ireg = BUBBLE;
      m_out = m_out - int'(imem_rvalid);
      m_disc = m_out;
      last_valid = 0;
    end else begin
      if (grant) begin
        m_fetch = m_fetch + 32'd4;
        m_out++;
      end
      if (imem_rvalid) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          acc = 1;
          m_resp = m_resp + 32'd4;
        end
      end
      if (m_q.size() > 0) begin
        m_ireg = m_q.pop_front();
        if (acc) m_q.push_back(w);
      end else if (acc && BYP == 1) begin
        m_ireg = w;
      end else begin
        m_ireg = BUBBLE;
        if (acc) m_q.push_back(w);
      end
    end
  endtask

  // One clock cycle: memory drives response, outputs compared at negedge, model stepped
  task automatic step_cycle();
    pend_t p;
    bit grant;
    int d;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (!hold_rv && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(p.addr);
    end
    @(negedge i_clk);
    s_req = imem_req;
    s_addr = imem_addr;
    s_ireg = instruction_reg;
    check("ireg", s_ireg, m_ireg);
    check("req", 64'(s_req), 64'(m_req()));
    check("addr", 64'(s_addr), 64'(m_fetch));
    if (s_ireg !== BUBBLE) begin
      check("word_data", 64'(s_ireg[31:0]), 64'(mem_word(s_ireg[63:32])));
      if (last_valid) check("pc_seq", 64'(s_ireg[63:32]), 64'(last_pc + 32'd4));
      last_pc = s_ireg[63:32];
      last_valid = 1;
    end
    grant = m_req() && imem_gnt;
    if (grant) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: m_fetch, due: d});
    end
    model_step(grant);
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic wait_word(input string name, input int bound, output int k, output logic [63:0] w);
    for (k = 1; k <= bound; k++) begin
      step_cycle();
      if (s_ireg !== BUBBLE) break;
    end
    w = s_ireg;
    if (k > bound) begin
      checks++;
      errors++;
      $display("FAIL %s: no instruction within %0d cycles, got %h expected non-bubble", name, bound, w);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp1 [3];
    logic [63:0] w;
    int k;
    int ngr;
    exp1 = '{64'h0000_0000_1000_0000, 64'h0000_0004_1000_0004, 64'h0000_0008_1000_0008};

    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ireg", instruction_reg, BUBBLE);
    check("rst_req", 64'(imem_req), 64'd1);
    check("rst_addr", 64'(imem_addr), 64'(RESET_PC));

    // Reset release, 1-cycle memory, continuous grant
    i_rstn = 1'b1;
    imem_gnt = 1'b1;
    lat = 1;
    cyc = 0;
    for (int c = 0; c < 6 - BYP; c++) begin
      step_cycle();
      if (c < 3 - BYP) check("t1_bubble", s_ireg, BUBBLE);
      else check("t1_word", s_ireg, exp1[c - (3 - BYP)]);
    end

    // Grant stall with fetch_pc parked at 0x10
    update_pc = 1'b1; new_pc = 32'h10;
    step_cycle();
    update_pc = 1'b0;
    imem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step_cycle();
      check("t2_req_held", 64'(s_req), 64'd1);
      check("t2_addr_held", 64'(s_addr), 64'h10);
    end
    check("t2_bubble", s_ireg, BUBBLE);
    imem_gnt = 1'b1;
    wait_word("t2_resume", 12, k, w);
    check("t2_first", w, 64'h0000_0010_1000_0010);

    // Redirect with two requests in flight, latency 3
    imem_gnt = 1'b0;
    run(8);
    lat = 3;
    imem_gnt = 1'b1;
    run(2);
    imem_gnt = 1'b0;
    update_pc = 1'b1; new_pc = 32'h100;
    step_cycle();
    check("t3_noreq", 64'(s_req), 64'd0);
    update_pc = 1'b0;
    imem_gnt = 1'b1;
    step_cycle();
    check("t3_bubble", s_ireg, BUBBLE);
    wait_word("t3_target", 20, k, w);
    check("t3_first", w, 64'h0000_0100_1000_0100);

    // Capacity backpressure with responses withheld
    lat = 1;
    imem_gnt = 1'b0;
    run(10);
    hold_rv = 1'b1;
    imem_gnt = 1'b1;
    ngr = 0;
    for (int c = 0; c < 8; c++) begin
      step_cycle();
      ngr += int'(s_req);
    end
    check("t4_grants", 64'(ngr), 64'd4);
    check("t4_req_low", 64'(s_req), 64'd0);
    hold_rv = 1'b0;
    step_cycle();
    check("t4_rvalid_cycle", 64'(s_req), 64'd0);
    step_cycle();
    check("t4_reassert", 64'(s_req), 64'(BYP));
    step_cycle();
    check("t4_reassert_late", 64'(s_req), 64'd1);

    // Misaligned redirect target
    imem_gnt = 1'b0;
    run(10);
    update_pc = 1'b1; new_pc = 32'h203;
    step_cycle();
    update_pc = 1'b0;
    imem_gnt = 1'b1;
    step_cycle();
    check("t5_addr", 64'(s_addr), 64'h200);
    check("t5_req", 64'(s_req), 64'd1);
    wait_word("t5_target", 12, k, w);
    check("t5_first", w, 64'h0000_0200_1000_0200);

    // Reset in the middle of a burst at 0x40
    update_pc = 1'b1; new_pc = 32'h40;
    step_cycle();
    update_pc = 1'b0;
    run(5);
    i_rstn = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("t6_rst_ireg", instruction_reg, BUBBLE);
    check("t6_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    check("t6_rst_req", 64'(imem_req), 64'd1);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    cyc = 0;
    wait_word("t6_restart", 10, k, w);
    check("t6_first", w, {RESET_PC, mem_word(RESET_PC)});
    check("t6_latency", 64'(k), 64'(4 - BYP));

    // Randomized traffic: grant stalls, variable latency, redirects
    for (int c = 0; c < 3000; c++) begin
      imem_gnt = ($urandom_range(9) < 7);
      lat = 1 + int'($urandom_range(3));
      update_pc = ($urandom_range(31) == 0);
      new_pc = $urandom;
      step_cycle();
    end
    update_pc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
